instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Pipeline IF stage feeding the decode stage.
- Owns the word-addressed PC register and the IF/ID pipeline register.
- Applies hazard stalls, branch/jump redirects with flush, and HALT detection via a small state machine.
- Outputs (o_instruction, o_PCNext) drive decode's i_instruction and i_PCNext directly.

Parameters:
- PC_BITS, 32, PC and address width (word address).
- INSTRUCTION_BITS, 32, instruction width.
- HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch.
- NOP_WORD, 32'h00000000, bubble inserted on flush or while halted.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_enable  in  1  global run enable; low freezes all state.
- i_PCWrite  in  1  from hazard detector; low holds PC.
- i_if_id_write  in  1  from hazard detector; low holds IF/ID.
- i_branch  in  1  taken branch resolved downstream.
- i_branch_address  in  PC_BITS  branch target.
- i_jump  in  1  jump from decode.
- i_jump_address  in  PC_BITS  jump target.
- o_imem_addr  out  PC_BITS  instruction memory address; equals PC.
- i_imem_data  in  INSTRUCTION_BITS  combinational-read memory data for o_imem_addr.
- o_instruction  out  INSTRUCTION_BITS  IF/ID instruction.
- o_PCNext  out  PC_BITS  IF/ID PC+1 of that instruction.
- o_pc  out  PC_BITS  current PC (debug).
- o_halted  out  1  high in HALTED state.

Behaviour:
- Reset (rst low, asynchronous):
  - PC=0, o_instruction=NOP_WORD, o_PCNext=0, state=RUN, o_halted=0.
  - Reset mid-operation discards everything immediately.
- o_imem_addr = PC, combinational. Fetched word = i_imem_data in the same cycle.
- i_enable low: PC, IF/ID and state hold; all other inputs ignored.
- Redirect = i_branch | i_jump. Target = i_branch_address if i_branch, else i_jump_address. Branch wins when both are asserted (older instruction).
- States: RUN, HALTED.
- RUN, each enabled edge, first match applies:
  1. Redirect: PC<=target, IF/ID<={NOP_WORD, 0}. Overrides i_PCWrite/i_if_id_write low.
  2. Else, i_PCWrite low: PC holds. IF/ID holds if i_if_id_write low, else loads NOP_WORD with o_PCNext held. No HALT detection while stalled.
  3. Else, fetched word == HALT_WORD: IF/ID<={HALT_WORD, PC+1}, PC holds, state->HALTED.
  4. Else: PC<=PC+1, IF/ID<={i_imem_data, PC+1}.
- HALTED, each enabled edge:
  - i_branch: the halt was speculative. PC<=i_branch_address, IF/ID<=NOP, state->RUN.
  - i_jump is ignored in HALTED, since decode holds HALT or NOP.
  - Otherwise PC holds and IF/ID loads NOP (HALT is presented exactly one cycle).
  - Stall inputs are honoured: i_if_id_write low holds IF/ID.
- o_halted = (state==HALTED), registered.
- Arithmetic: PC+1 wraps modulo 2^PC_BITS, so 0xFFFFFFFF+1 = 0. No other width extension.
- Latency: an instruction at address A reaches o_instruction one edge after PC==A with no stall. Redirect bubble is one cycle.

Optional Feature:
- Macro IF_STEP_MODE_EN.
- Defined:
  - Adds input i_step (1 bit).
  - While i_enable is low, an edge with i_step high performs exactly one RUN/HALTED update as if enabled.
  - i_step is level-sampled; the debug unit guarantees a single-cycle pulse.
  - i_step is ignored while i_enable is high.
- Undefined: no i_step port; behaviour exactly as above.

Test Plan:
- Reset, enable high, memory word[k]=k+0x100: after 3 edges, PC=3, o_instruction=0x102, o_PCNext=3, o_halted=0.
- At PC=5, i_PCWrite=0 and i_if_id_write=0 for 2 cycles: PC stays 5 and IF/ID is unchanged. Releasing them resumes with o_instruction=word[5], o_PCNext=6.
- At PC=8, i_branch=1 with target 0x40, i_jump=1 with target 0x80, and i_PCWrite=0 all at once: next PC=0x40, o_instruction=NOP. Following edge: word[0x40], o_PCNext=0x41.
- word[10]=HALT_WORD: after it is fetched, o_instruction=HALT_WORD, o_PCNext=11, PC=10, o_halted=1. Next edge: o_instruction=NOP, and PC stays 10 for 5 more cycles.
- HALTED, then i_branch=1 with target 0x20: o_halted=0, PC=0x20, o_instruction=NOP. Next edge: word[0x20].
- PC=0xFFFFFFFF, no stall: next PC=0, o_PCNext=0. With IF_STEP_MODE_EN, enable low and one i_step pulse: PC advances exactly by 1.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage owning the PC and IF/ID register, with stall, redirect and HALT handling.
// Optional single-step debug input enabled by defining IF_STEP_MODE_EN.
module instruction_fetch #(
  parameter int PC_BITS = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [INSTRUCTION_BITS-1:0] NOP_WORD = 32'h00000000
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef IF_STEP_MODE_EN
  input  logic                        i_step,
`endif
  input  logic                        i_enable,
  input  logic                        i_PCWrite,
  input  logic                        i_if_id_write,
  input  logic                        i_branch,
  input  logic [PC_BITS-1:0]          i_branch_address,
  input  logic                        i_jump,
  input  logic [PC_BITS-1:0]          i_jump_address,
  output logic [PC_BITS-1:0]          o_imem_addr,
  input  logic [INSTRUCTION_BITS-1:0] i_imem_data,
  output logic [INSTRUCTION_BITS-1:0] o_instruction,
  output logic [PC_BITS-1:0]          o_PCNext,
  output logic [PC_BITS-1:0]          o_pc,
  output logic                        o_halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [PC_BITS-1:0] pc, pc_nx, pcn_nx, pc_inc, target;
  logic [INSTRUCTION_BITS-1:0] instr_nx;
  logic upd, redirect;
`ifdef IF_STEP_MODE_EN
  assign upd = i_enable | i_step;
`else
  assign upd = i_enable;
`endif
  assign pc_inc = pc + 1'b1;
  assign redirect = i_branch | i_jump;
  assign target = i_branch ? i_branch_address : i_jump_address;
  assign o_imem_addr = pc;
  assign o_pc = pc;
  assign o_halted = (state == HALTED);
  always_comb begin
    pc_nx = pc;
    instr_nx = o_instruction;
    pcn_nx = o_PCNext;
    state_nx = state;
    if (state == RUN) begin
      if (redirect) begin
        pc_nx = target;
        instr_nx = NOP_WORD;
        pcn_nx = '0;
      end else if (!i_PCWrite) begin
        instr_nx = i_if_id_write ? NOP_WORD : o_instruction;
      end else if (i_imem_data == HALT_WORD) begin
        instr_nx = HALT_WORD;
        pcn_nx = pc_inc;
        state_nx = HALTED;
      end else begin
        pc_nx = pc_inc;
        instr_nx = i_imem_data;
        pcn_nx = pc_inc;
      end
    end else if (i_branch) begin
      // the halt was fetched down a mispredicted path; resume at the target
      pc_nx = i_branch_address;
      instr_nx = NOP_WORD;
      pcn_nx = '0;
      state_nx = RUN;
    end else begin
      instr_nx = i_if_id_write ? NOP_WORD : o_instruction;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      o_instruction <= NOP_WORD;
      o_PCNext <= '0;
      state <= RUN;
    end else if (upd) begin
      pc <= pc_nx;
      o_instruction <= instr_nx;
      o_PCNext <= pcn_nx;
      state <= state_nx;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plan plus randomized run against a behavioural model of the IF stage.
module tb_instruction_fetch;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NOP = 32'h00000000;
`ifdef IF_STEP_MODE_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic en = 1'b0, pcw = 1'b0, ifw = 1'b0, br = 1'b0, jp = 1'b0, step = 1'b0;
  logic [31:0] ba = '0, ja = '0, imem_addr, imem_data, instr, pcn, pc;
  logic halted;
  logic [31:0] m_pc, m_instr, m_pcn;
  bit m_halted;
  int checks = 0, errors = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'd10) ? HALT : a + 32'h100;
  endfunction

  assign imem_data = word(imem_addr);

  instruction_fetch dut (
    .clk(clk), .rst(rst),
`ifdef IF_STEP_MODE_EN
    .i_step(step),
`endif
    .i_enable(en), .i_PCWrite(pcw), .i_if_id_write(ifw),
    .i_branch(br), .i_branch_address(ba), .i_jump(jp), .i_jump_address(ja),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_instruction(instr), .o_PCNext(pcn), .o_pc(pc), .o_halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("addr", imem_addr, m_pc);
    check("instr", instr, m_instr);
    check("pcnext", pcn, m_pcn);
    check("halted", {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = NOP; m_pcn = '0; m_halted = 0;
  endtask

  // Applies the architectural rules for one clock edge to the model state.
  task automatic model_edge();
    logic [31:0] w;
    w = word(m_pc);
    if (!(en || (STEP && step))) return;
    if (!m_halted) begin
      if (br || jp) begin
        m_pc = br ? ba : ja; m_instr = NOP; m_pcn = '0;
      end else if (!pcw) begin
        if (ifw) m_instr = NOP;
      end else if (w == HALT) begin
        m_instr = HALT; m_pcn = m_pc + 1; m_halted = 1;
      end else begin
        m_instr = w; m_pcn = m_pc + 1; m_pc = m_pc + 1;
      end
    end else if (br) begin
      m_pc = ba; m_instr = NOP; m_pcn = '0; m_halted = 0;
    end else if (ifw) begin
      m_instr = NOP;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    en = 1; pcw = 1; ifw = 1; br = 0; jp = 0; step = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1;
    idle();
    repeat (3) tick();
    check("plan_pc3", pc, 32'd3);
    check("plan_i102", instr, 32'h102);
    repeat (2) tick();
    pcw = 0; ifw = 0;
    repeat (2) tick();
    check("stall_pc", pc, 32'd5);
    idle();
    tick();
    check("resume_i", instr, 32'h105);
    repeat (2) tick();
    br = 1; ba = 32'h40; jp = 1; ja = 32'h80; pcw = 0;
    tick();
    check("branch_pc", pc, 32'h40);
    idle();
    tick();
    check("branch_i", instr, 32'h140);
    jp = 1; ja = 32'd7;
    tick();
    idle();
    repeat (4) tick();
    check("halt_i", instr, HALT);
    check("halt_pcn", pcn, 32'd11);
    check("halt_pc", pc, 32'd10);
    repeat (5) tick();
    check("halted_pc", pc, 32'd10);
    check("halted_i", instr, NOP);
    jp = 1; ja = 32'h33;
    tick();
    check("halt_jump_ignored", pc, 32'd10);
    jp = 0; br = 1; ba = 32'h20;
    tick();
    check("unhalt", {31'b0, halted}, 32'd0);
    idle();
    tick();
    check("unhalt_i", instr, 32'h120);
    jp = 1; ja = 32'hFFFFFFFF;
    tick();
    idle();
    tick();
    check("wrap_pc", pc, 32'd0);
    check("wrap_pcn", pcn, 32'd0);
    en = 0;
    tick();
    check("en_hold", pc, 32'd0);
    step = 1;
    tick();
    step = 0;
    repeat (2) tick();
    check("step_pc", pc, STEP ? 32'd1 : 32'd0);
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(9) != 0);
      step = ($urandom_range(3) == 0);
      pcw = ($urandom_range(6) != 0);
      ifw = ($urandom_range(6) != 0);
      br = ($urandom_range(11) == 0);
      jp = ($urandom_range(11) == 0);
      ba = $urandom_range(63);
      ja = $urandom_range(63);
      tick();
    end
    idle();
    tick();
    #2 rst = 0;
    #1;
    model_reset();
    check_all();
    #1 rst = 1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
